alu_mult_seq: RTL and testbench

Multi-cycle unsigned 32x32->64 multiplier controller that performs shift-and-add by driving the existing alu_32 datapath rather than instantiating its own adder. It sits beside alu_32 and sequences one ADD per cycle through the ALU's a/b/control ports. It gives the core a single-issue start/busy/done multiply unit. While idle it drives the ALU with zeros so a top-level mux can share the ALU.

---
 rtl/alu_mult_seq.sv | 136 +++++++++++++
 tb/tb_alu_mult_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_seq.sv
// Sequential shift-and-add multiplier that borrows the shared alu_32 for one ADD per cycle.
// Optional signed support is compiled in with `define ALU_MULT_SIGNED_EN.
module alu_mult_seq #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] ALU_ADD = 4'h2,
  parameter int         CNT_W   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  input  logic                 signed_op,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 alu_req,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_control,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_cout,
  output logic [1:0]           state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]           state;
  logic [WIDTH-1:0]     mcand_r;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 last_iter;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  assign hi        = acc[2*WIDTH-1:WIDTH];
  assign lo        = acc[WIDTH-1:0];
  // 33-bit ALU sum shifted right one place; carry lands in the top bit.
  assign acc_next  = {alu_cout, alu_result, lo[WIDTH-1:1]};
  assign last_iter = (cnt == CNT_W'(WIDTH-1));

`ifdef ALU_MULT_SIGNED_EN
  logic signed_r;
  logic neg_r;
  logic neg_in;

  // Operate on magnitudes; the sign is reapplied in the FIX cycle.
  assign a_mag  = (signed_op && mcand[WIDTH-1])  ? -mcand  : mcand;
  assign b_mag  = (signed_op && mplier[WIDTH-1]) ? -mplier : mplier;
  assign neg_in = signed_op && (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
`else
  logic unused_signed_op;

  assign a_mag            = mcand;
  assign b_mag            = mplier;
  assign unused_signed_op = signed_op;
`endif

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = '0;
    if (state == S_RUN) begin
      alu_a       = hi;
      alu_b       = lo[0] ? mcand_r : '0;
      alu_control = ALU_ADD;
    end
  end

  assign busy      = (state == S_RUN) || (state == S_FIX);
  assign alu_req   = busy;
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      mcand_r <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
`ifdef ALU_MULT_SIGNED_EN
      signed_r <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand_r <= a_mag;
            acc     <= {{WIDTH{1'b0}}, b_mag};
            cnt     <= '0;
            state   <= S_RUN;
`ifdef ALU_MULT_SIGNED_EN
            signed_r <= signed_op;
            neg_r    <= neg_in;
`endif
          end
        end
        S_RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
`ifdef ALU_MULT_SIGNED_EN
            if (signed_r) begin
              state <= S_FIX;
            end else begin
              product <= acc_next;
              state   <= S_DONE;
            end
`else
            product <= acc_next;
            state   <= S_DONE;
`endif
          end
        end
`ifdef ALU_MULT_SIGNED_EN
        S_FIX: begin
          acc     <= neg_r ? -acc : acc;
          product <= neg_r ? -acc : acc;
          state   <= S_DONE;
        end
`endif
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: a behavioural alu_32 ADD model feeds the datapath,
// products are checked against plain 64-bit arithmetic.
module tb_alu_mult_seq;

`ifdef ALU_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        signed_op;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        alu_req;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_cout;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- alu_32 stand-in (ADD only) ----------------
  always_comb begin
    {alu_cout, alu_result} = 33'd0;
    if (alu_control == 4'h2) {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
  end

  alu_mult_seq dut (
    .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
    .signed_op(signed_op), .busy(busy), .done(done), .product(product),
    .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_cout(alu_cout), .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s && SIGNED_EN) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic int ref_lat(input logic s);
    return (s && SIGNED_EN) ? 34 : 33;
  endfunction

  // ---------------- driver ----------------
  // Issues one start; returns cycles to done (60 = timeout), the product seen
  // with done, and counts of cycles with wrong busy/alu_req or wrong ALU opcode.
  // ign_at > 0 pulses a second start with fresh operands in that RUN cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int ign_at, output int lat, output logic [63:0] prod,
                       output int busy_bad, output int ctl_bad);
    @(negedge clk);
    mcand = a; mplier = b; signed_op = s; start = 1'b1;
    lat = 0; busy_bad = 0; ctl_bad = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      start  = 1'b0;
      mcand  = $urandom;
      mplier = $urandom;
      if (lat == ign_at) start = 1'b1;
      if (done) break;
      if (!busy || !alu_req) busy_bad++;
      if (lat <= 32 && alu_control !== 4'h2) ctl_bad++;
    end
    start = 1'b0;
    prod  = product;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0; signed_op = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, alu_req, alu_control, alu_a, alu_b, product} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b done=%b req=%b ctl=%h a=%h b=%h prod=%h, required all 0",
               busy, done, alu_req, alu_control, alu_a, alu_b, product);
    end
  endtask

  task automatic test_basic;
    int lat, bb, cb;
    logic [63:0] prod, exp;
    exp_q.push_back(ref_mul(32'd1234, 32'd4321, 1'b0));
    do_op(32'd1234, 32'd4321, 1'b0, 0, lat, prod, bb, cb);
    exp = exp_q.pop_front();
    n_cmp++;
    if (prod !== exp) begin n_err++; $display("FAIL basic_product: got %0d required %0d", prod, exp); end
    n_cmp++;
    if (lat !== 33) begin n_err++; $display("FAIL basic_latency: got %0d required 33", lat); end
    n_cmp++;
    if (bb !== 0 || cb !== 0) begin n_err++; $display("FAIL basic_busy_ctl: bad busy cycles %0d bad ctl cycles %0d required 0", bb, cb); end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || product !== exp) begin
      n_err++; $display("FAIL basic_pulse_hold: done=%b prod=%h required done=0 prod=%h", done, product, exp);
    end
  endtask

  task automatic test_edges;
    logic [31:0] ea [3] = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0001};
    logic [31:0] eb [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    int lat, bb, cb;
    logic [63:0] prod, exp;
    n_cmp++;
    if (ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0) !== 64'hFFFF_FFFE_0000_0001) begin
      n_err++; $display("FAIL model_ffff: got %h required fffffffe00000001", ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0));
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ref_mul(ea[i], eb[i], 1'b0));
      do_op(ea[i], eb[i], 1'b0, 0, lat, prod, bb, cb);
      exp = exp_q.pop_front();
      n_cmp++;
      if (prod !== exp || lat !== 33) begin
        n_err++; $display("FAIL edge_%0d: got %h lat %0d required %h lat 33", i, prod, lat, exp);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_ignored_start;
    int lat, bb, cb;
    logic [63:0] prod, exp;
    exp_q.push_back(ref_mul(32'h0001_2345, 32'h0000_6789, 1'b0));
    do_op(32'h0001_2345, 32'h0000_6789, 1'b0, 10, lat, prod, bb, cb);
    exp = exp_q.pop_front();
    n_cmp++;
    if (prod !== exp || lat !== 33 || bb !== 0) begin
      n_err++; $display("FAIL ignored_start: got %h lat %0d busy_bad %0d required %h lat 33 busy_bad 0", prod, lat, bb, exp);
    end
    // the stray start must not have queued a second operation
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL ignored_no_queue: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bb, cb;
    logic [63:0] prod, exp;
    logic [31:0] a, b;
    for (int i = 0; i < 2; i++) begin
      a = $urandom; b = $urandom;
      exp_q.push_back(ref_mul(a, b, 1'b0));
      do_op(a, b, 1'b0, 0, lat, prod, bb, cb);
      exp = exp_q.pop_front();
      n_cmp++;
      if (prod !== exp || lat !== 33) begin
        n_err++; $display("FAIL back_to_back_%0d: got %h lat %0d required %h lat 33", i, prod, lat, exp);
      end
      @(posedge clk);   // next negedge falls in the IDLE cycle right after DONE
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, bb, cb, n;
    logic [63:0] prod, exp;
    logic saw_done;
    @(negedge clk);
    mcand = 32'hDEAD_BEEF; mplier = 32'h1234_5678; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (n = 1; n < 15; n++) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, alu_req, alu_control, alu_a, alu_b, product} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_run: busy=%b done=%b req=%b ctl=%h a=%h b=%h prod=%h, required all 0",
               busy, done, alu_req, alu_control, alu_a, alu_b, product);
    end
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    n_cmp++;
    if (saw_done !== 1'b0) begin n_err++; $display("FAIL reset_no_done: done seen=%b required 0", saw_done); end
    exp_q.push_back(ref_mul(32'd3, 32'd7, 1'b0));
    do_op(32'd3, 32'd7, 1'b0, 0, lat, prod, bb, cb);
    exp = exp_q.pop_front();
    n_cmp++;
    if (prod !== exp || lat !== 33) begin
      n_err++; $display("FAIL after_reset_3x7: got %0d lat %0d required %0d lat 33", prod, lat, exp);
    end
    @(posedge clk);
  endtask

  task automatic test_random;
    int lat, bb, cb;
    logic [63:0] prod, exp;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      a = (i % 2) ? 32'($urandom_range(0, 1000)) : $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      exp_q.push_back(ref_mul(a, b, 1'b0));
      do_op(a, b, 1'b0, 0, lat, prod, bb, cb);
      exp = exp_q.pop_front();
      n_cmp++;
      if (prod !== exp || lat !== 33 || bb !== 0 || cb !== 0) begin
        n_err++; $display("FAIL random_%0d: %h x %h got %h lat %0d (bb %0d cb %0d) required %h lat 33",
                          i, a, b, prod, lat, bb, cb, exp);
      end
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end
  endtask

  task automatic test_signed;
    logic [31:0] sa [4] = '{32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h8000_0000, 32'h0000_0009};
    logic [31:0] sb [4] = '{32'd7,        32'd7,        32'h8000_0000, 32'hFFFF_FFFD};
    logic        ss [4] = '{1'b1,         1'b0,         1'b1,          1'b1};
    int lat, bb, cb;
    logic [63:0] prod, exp;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ref_mul(sa[i], sb[i], ss[i]));
      do_op(sa[i], sb[i], ss[i], 0, lat, prod, bb, cb);
      exp = exp_q.pop_front();
      n_cmp++;
      if (prod !== exp || lat !== ref_lat(ss[i]) || bb !== 0) begin
        n_err++; $display("FAIL signed_%0d: got %h lat %0d busy_bad %0d required %h lat %0d",
                          i, prod, lat, bb, exp, ref_lat(ss[i]));
      end
      @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    test_signed();
    n_cmp++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
